// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display path: active-low patterns
// (bit0=a .. bit6=g), converter state encoding and the displayable maximum.
package seg7_pkg;

  localparam int NUM_DIGITS  = 6;
  localparam int MAX_DISPLAY = 999999;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment encoder.
// Non-decimal nibbles (10..15) render as blank.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bin_to_seg_digits.sv
// Serial double-dabble binary-to-BCD converter driving six registered digit patterns.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the most-significant non-zero one.
module bin_to_seg_digits
  import seg7_pkg::*;
#(
  parameter int IN_WIDTH = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] value,
  output logic                busy,
  output logic                done,
  output logic [6:0]          seg0,
  output logic [6:0]          seg1,
  output logic [6:0]          seg2,
  output logic [6:0]          seg3,
  output logic [6:0]          seg4,
  output logic [6:0]          seg5
);

  localparam int CNT_W = $clog2(IN_WIDTH + 1);

  state_t                         state_q, state_d;
  logic [IN_WIDTH-1:0]            bin_q, bin_d;
  logic [4*NUM_DIGITS-1:0]        bcd_q, bcd_d, bcd_adj, bcd_shift;
  logic                           bcd_carry;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           ovf_q, ovf_d;
  logic [NUM_DIGITS-1:0][6:0]     seg_q, seg_d;
  logic [NUM_DIGITS-1:0][6:0]     enc;
  logic [NUM_DIGITS-1:0]          blank_mask;

  // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd,bin} left.
  // The carry out of the top nibble only happens for out-of-range operands.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    {bcd_carry, bcd_shift} = {bcd_adj, bin_q[IN_WIDTH-1]};
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
    bcd_to_seg7 u_enc (
      .bcd (bcd_shift[4*g +: 4]),
      .seg (enc[g])
    );
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lead;

  always_comb begin
    blank_mask = '0;
    lead       = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (bcd_shift[4*i +: 4] != 4'd0) begin
        lead = 1'b0;
      end
      blank_mask[i] = lead;
    end
  end
`else
  assign blank_mask = '0;
`endif

  // Segments load on the final shift edge so they appear together with done in LOAD.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    seg_d   = seg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = value;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = (value > IN_WIDTH'(MAX_DISPLAY));
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bin_d = {bin_q[IN_WIDTH-2:0], 1'b0};
        bcd_d = bcd_shift;
        cnt_d = cnt_q + 1'b1;
        ovf_d = ovf_q | bcd_carry;
        if (cnt_d == CNT_W'(IN_WIDTH)) begin
          state_d = LOAD;
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (ovf_d) begin
              seg_d[i] = SEG_DASH;
            end else if (blank_mask[i]) begin
              seg_d[i] = SEG_BLANK;
            end else begin
              seg_d[i] = enc[i];
            end
          end
        end
      end
      LOAD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      seg_q   <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      seg_q   <= seg_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == LOAD);
  assign seg0 = seg_q[0];
  assign seg1 = seg_q[1];
  assign seg2 = seg_q[2];
  assign seg3 = seg_q[3];
  assign seg4 = seg_q[4];
  assign seg5 = seg_q[5];

endmodule

// File: tb/tb_bin_to_seg_digits.sv
// Directed table-driven bench for bin_to_seg_digits, plus hand-written
// sequences for ignored starts, reset abort and output hold.
module tb_bin_to_seg_digits;

  localparam logic [6:0] D0 = 7'b1000000;
  localparam logic [6:0] D1 = 7'b1111001;
  localparam logic [6:0] D2 = 7'b0100100;
  localparam logic [6:0] D3 = 7'b0110000;
  localparam logic [6:0] D4 = 7'b0011001;
  localparam logic [6:0] D5 = 7'b0010010;
  localparam logic [6:0] D6 = 7'b0000010;
  localparam logic [6:0] D7 = 7'b1111000;
  localparam logic [6:0] D8 = 7'b0000000;
  localparam logic [6:0] D9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DA = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = BL;
`else
  localparam logic [6:0] LZ = D0;
`endif
  localparam int LATENCY = 21;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] value;
  logic        busy;
  logic        done;
  logic [6:0]  seg0, seg1, seg2, seg3, seg4, seg5;

  int cyc = 0;
  int start_cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic [19:0] v;
    logic [41:0] exp;
  } vec_t;

  vec_t vecs [11];

  bin_to_seg_digits #(.IN_WIDTH(20)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (done),
    .seg0  (seg0),
    .seg1  (seg1),
    .seg2  (seg2),
    .seg3  (seg3),
    .seg4  (seg4),
    .seg5  (seg5)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [41:0] segs();
    return {seg5, seg4, seg3, seg2, seg1, seg0};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives a one-cycle start on the next negedge; returns at the first negedge after acceptance.
  task automatic applyStimulus(input logic [19:0] v);
    @(negedge clk);
    value = v;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int busy_n);
    int guard;
    guard  = 0;
    busy_n = 0;
    while (!done && guard < 100) begin
      if (busy) busy_n++;
      @(negedge clk);
      guard++;
    end
    if (busy) busy_n++;
  endtask

  task automatic countDones(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  initial begin
    int bn;
    int pulses;

    vecs[0]  = '{20'd123456,  {D1, D2, D3, D4, D5, D6}};
    vecs[1]  = '{20'd999999,  {D9, D9, D9, D9, D9, D9}};
    vecs[2]  = '{20'd0,       {LZ, LZ, LZ, LZ, LZ, D0}};
    vecs[3]  = '{20'd1000000, {DA, DA, DA, DA, DA, DA}};
    vecs[4]  = '{20'd100005,  {D1, D0, D0, D0, D0, D5}};
    vecs[5]  = '{20'd42,      {LZ, LZ, LZ, LZ, D4, D2}};
    vecs[6]  = '{20'hFFFFF,   {DA, DA, DA, DA, DA, DA}};
    vecs[7]  = '{20'd999,     {LZ, LZ, LZ, D9, D9, D9}};
    vecs[8]  = '{20'd7,       {LZ, LZ, LZ, LZ, LZ, D7}};
    vecs[9]  = '{20'd88,      {LZ, LZ, LZ, LZ, D8, D8}};
    vecs[10] = '{20'd100000,  {D1, D0, D0, D0, D0, D0}};

    rst   = 1'b1;
    start = 1'b0;
    value = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", {busy, done, segs()}, {1'b0, 1'b0, {6{BL}}});
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_after_reset", {busy, done, segs()}, {1'b0, 1'b0, {6{BL}}});

    // Consecutive entries run back-to-back: each start lands in the cycle after done.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].v);
      waitDone(bn);
      checkOutput($sformatf("latency[%0d]", i), cyc - start_cyc, LATENCY);
      checkOutput($sformatf("busy_cycles[%0d]", i), bn, LATENCY);
      checkOutput($sformatf("segs[%0d]", i), segs(), vecs[i].exp);
    end

    @(negedge clk);
    checkOutput("done_single_pulse", {busy, done}, 2'b00);
    repeat (10) @(negedge clk);
    checkOutput("segs_hold", segs(), vecs[10].exp);

    // A start during a conversion, with a changed operand, is ignored.
    applyStimulus(20'd42);
    repeat (4) @(negedge clk);
    value = 20'd777;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(bn);
    checkOutput("ignore_latency", cyc - start_cyc, LATENCY);
    checkOutput("ignore_segs", segs(), {LZ, LZ, LZ, LZ, D4, D2});
    countDones(30, pulses);
    checkOutput("ignore_no_second_done", pulses, 0);
    checkOutput("ignore_idle", busy, 1'b0);

    // Reset mid-conversion aborts without a done and blanks the outputs.
    applyStimulus(20'd555555);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_state", {busy, done, segs()}, {1'b0, 1'b0, {6{BL}}});
    rst = 1'b0;
    countDones(30, pulses);
    checkOutput("abort_no_done", pulses, 0);
    checkOutput("abort_segs_blank", segs(), {6{BL}});

    applyStimulus(20'd123456);
    waitDone(bn);
    checkOutput("post_abort_latency", cyc - start_cyc, LATENCY);
    checkOutput("post_abort_busy", bn, LATENCY);
    checkOutput("post_abort_segs", segs(), {D1, D2, D3, D4, D5, D6});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
